// File: rtl/uart_rx_param_pkg.sv
// Shared constants and helpers for the parametrised UART receive path.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  function automatic int bit_cnt(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Line-side and system-side signals of the UART receiver.
interface uart_rx_param_if #(parameter int DATA_BITS = 8);
  logic                 rx_en_sig;
  logic                 rx_pin;
  logic                 rx_done;
  logic [DATA_BITS-1:0] rx_data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (output rx_en_sig, output rx_pin,
                  input rx_done, input rx_data, input parity_err, input frame_err, input rx_busy);
  modport slave  (input rx_en_sig, input rx_pin,
                  output rx_done, output rx_data, output parity_err, output frame_err, output rx_busy);
endinterface

// File: rtl/uart_rx_param_sampler.sv
// Synchroniser, start-edge detect and 3-sample mid-bit majority vote.
module uart_rx_sampler #(
  parameter int BIT_CNT = 20,
  parameter int TW      = $clog2(BIT_CNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_rx_pin,
  input  logic [TW-1:0] i_timer,
  output logic          o_fall_edge,
  output logic          o_bit_val,
  output logic          o_sample_strobe
);
  localparam int MID = BIT_CNT / 2;
  localparam logic [TW-1:0] T_MID_M1 = TW'(MID - 1);
  localparam logic [TW-1:0] T_MID    = TW'(MID);
  localparam logic [TW-1:0] T_MID_P1 = TW'(MID + 1);

  logic r_sync1, r_sync2, r_hist, r_s0, r_s1;

  // Line synchroniser, edge history and the two early mid-bit samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
    end else begin
      r_sync1 <= i_rx_pin;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      if (i_timer == T_MID_M1) r_s0 <= r_sync2;
      if (i_timer == T_MID)    r_s1 <= r_sync2;
    end
  end

  // Third sample is the live synchronised line at MID+1.
  assign o_fall_edge     = r_hist & ~r_sync2;
  assign o_sample_strobe = (i_timer == T_MID_P1);
  assign o_bit_val       = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: start/data/parity/stop framing with error flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 20000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic            clk,
  input logic            rst_n,
  uart_rx_param_if.slave bus
);
  localparam int BIT_CNT = bit_cnt(CLK_HZ, BAUD);
  localparam int TW      = $clog2(BIT_CNT);
  localparam int BCW     = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0]  T_LAST    = TW'(BIT_CNT - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

  logic [2:0]           r_state, w_state_nxt;
  logic [TW-1:0]        r_timer, w_timer_nxt;
  logic [BCW-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_perr, w_perr_nxt, r_ferr, w_ferr_nxt;
  logic                 r_rx_done, w_rx_done_nxt;
  logic [DATA_BITS-1:0] r_rx_data, w_rx_data_nxt;
  logic                 r_parity_err, w_parity_err_nxt;
  logic                 r_frame_err, w_frame_err_nxt;
  logic                 r_rx_busy;
  logic                 w_fall_edge, w_bit_val, w_strobe, w_wrap;

  uart_rx_sampler #(.BIT_CNT(BIT_CNT), .TW(TW)) u_sampler (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_rx_pin        (bus.rx_pin),
    .i_timer         (r_timer),
    .o_fall_edge     (w_fall_edge),
    .o_bit_val       (w_bit_val),
    .o_sample_strobe (w_strobe)
  );

  assign w_wrap = (r_timer == T_LAST);

  // Next-state, datapath and output update logic for the frame FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = w_wrap ? {TW{1'b0}} : r_timer + TW'(1);
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_perr_nxt       = r_perr;
    w_ferr_nxt       = r_ferr;
    w_rx_done_nxt    = 1'b0;
    w_rx_data_nxt    = r_rx_data;
    w_parity_err_nxt = r_parity_err;
    w_frame_err_nxt  = r_frame_err;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = {TW{1'b0}};
        if (w_fall_edge && bus.rx_en_sig) begin
          w_state_nxt   = ST_START;
          w_bit_cnt_nxt = {BCW{1'b0}};
          w_perr_nxt    = 1'b0;
          w_ferr_nxt    = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_strobe && w_bit_val) w_state_nxt = ST_IDLE;
        else if (w_wrap)           w_state_nxt = ST_DATA;
        else                       w_state_nxt = ST_START;
      end
      ST_DATA: begin
        if (w_strobe) w_shift_nxt = {w_bit_val, r_shift[DATA_BITS-1:1]};
        else          w_shift_nxt = r_shift;
        if (w_wrap && (r_bit_cnt == DATA_LAST)) begin
          w_bit_cnt_nxt = {BCW{1'b0}};
          w_state_nxt   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end else if (w_wrap) begin
          w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
        end else begin
          w_bit_cnt_nxt = r_bit_cnt;
        end
      end
      ST_PARITY: begin
        if (w_strobe) w_perr_nxt = (PARITY == PAR_ODD) ? ~(^r_shift ^ w_bit_val) : (^r_shift ^ w_bit_val);
        else          w_perr_nxt = r_perr;
        if (w_wrap) w_state_nxt = ST_STOP;
        else        w_state_nxt = ST_PARITY;
      end
      ST_STOP: begin
        // Final stop bit completes at its mid-point so back-to-back frames are not missed.
        if (w_strobe && (r_bit_cnt == STOP_LAST)) begin
          w_state_nxt      = ST_DONE;
          w_ferr_nxt       = r_ferr | ~w_bit_val;
          w_rx_done_nxt    = 1'b1;
          w_rx_data_nxt    = r_shift;
          w_parity_err_nxt = r_perr;
          w_frame_err_nxt  = r_ferr | ~w_bit_val;
        end else if (w_strobe) begin
          w_ferr_nxt = r_ferr | ~w_bit_val;
        end else if (w_wrap) begin
          w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!bus.rx_en_sig && (r_state != ST_IDLE)) begin
      w_state_nxt      = ST_IDLE;
      w_rx_done_nxt    = 1'b0;
      w_rx_data_nxt    = r_rx_data;
      w_parity_err_nxt = r_parity_err;
      w_frame_err_nxt  = r_frame_err;
    end else begin
      w_rx_done_nxt = w_rx_done_nxt;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_timer      <= {TW{1'b0}};
      r_bit_cnt    <= {BCW{1'b0}};
      r_shift      <= {DATA_BITS{1'b0}};
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_rx_done    <= 1'b0;
      r_rx_data    <= {DATA_BITS{1'b0}};
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_rx_busy    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_perr       <= w_perr_nxt;
      r_ferr       <= w_ferr_nxt;
      r_rx_done    <= w_rx_done_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_rx_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.rx_done    = r_rx_done;
  assign bus.rx_data    = r_rx_data;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.rx_busy    = r_rx_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8N1, 8E1 and 7O2 instances at 20 clocks per bit.
module tb_uart_rx_param;
  localparam int BC = 20;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t qa[$], qb[$], qc[$];
  int   done_a = 0, done_b = 0, done_c = 0;
  int   na = 0, nb = 0, nc = 0;
  exp_t ea, eb, ec;

  uart_rx_param_if #(.DATA_BITS(8)) ifa ();
  uart_rx_param_if #(.DATA_BITS(8)) ifb ();
  uart_rx_param_if #(.DATA_BITS(7)) ifc ();

  uart_rx_param #(.CLK_HZ(20000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  uart_rx_param #(.CLK_HZ(20000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  uart_rx_param #(.CLK_HZ(20000000), .BAUD(1000000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pin(input int sel, input logic v);
    case (sel)
      0:       ifa.rx_pin = v;
      1:       ifb.rx_pin = v;
      default: ifc.rx_pin = v;
    endcase
  endtask

  task automatic hold(input int sel, input logic v, input int n);
    set_pin(sel, v);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input int nbits, input bit has_par,
                            input logic pbit, input int nstop, input logic s0, input logic s1);
    hold(sel, 1'b0, BC);
    for (int i = 0; i < nbits; i++) hold(sel, d[i], BC);
    if (has_par) hold(sel, pbit, BC);
    hold(sel, s0, BC);
    if (nstop == 2) hold(sel, s1, BC);
    hold(sel, 1'b1, 2 * BC);
  endtask

  // Scoreboard pops for each completed frame.
  always @(negedge clk) begin
    if (ifa.rx_done === 1'b1) begin
      done_a++;
      chk("a_done_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("a_rx_data", 32'(ifa.rx_data), 32'(ea.data));
        chk("a_parity_err", 32'(ifa.parity_err), 32'(ea.perr));
        chk("a_frame_err", 32'(ifa.frame_err), 32'(ea.ferr));
      end
    end
    if (ifb.rx_done === 1'b1) begin
      done_b++;
      chk("b_done_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("b_rx_data", 32'(ifb.rx_data), 32'(eb.data));
        chk("b_parity_err", 32'(ifb.parity_err), 32'(eb.perr));
        chk("b_frame_err", 32'(ifb.frame_err), 32'(eb.ferr));
      end
    end
    if (ifc.rx_done === 1'b1) begin
      done_c++;
      chk("c_done_expected", 32'(qc.size() != 0), 32'd1);
      if (qc.size() != 0) begin
        ec = qc.pop_front();
        chk("c_rx_data", 32'(ifc.rx_data), 32'(ec.data));
        chk("c_parity_err", 32'(ifc.parity_err), 32'(ec.perr));
        chk("c_frame_err", 32'(ifc.frame_err), 32'(ec.ferr));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ifa.rx_en_sig = 1'b1; ifa.rx_pin = 1'b1;
    ifb.rx_en_sig = 1'b1; ifb.rx_pin = 1'b1;
    ifc.rx_en_sig = 1'b1; ifc.rx_pin = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_a_outs", {27'd0, ifa.rx_done, ifa.parity_err, ifa.frame_err, ifa.rx_busy, 1'b0}, 32'd0);
    chk("rst_a_data", 32'(ifa.rx_data), 32'd0);
    chk("rst_c_outs", {ifc.rx_data, ifc.rx_done, ifc.parity_err, ifc.frame_err, ifc.rx_busy}, 32'd0);
    rst_n = 1'b1;
    hold(0, 1'b1, BC);

    // 8N1 clean frame
    qa.push_back('{9'h055, 1'b0, 1'b0}); na++;
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    chk("a_55_done_cnt", 32'(done_a), 32'(na));
    chk("a_55_busy_low", 32'(ifa.rx_busy), 32'd0);

    // 8E1: good then bad parity
    qb.push_back('{9'h0A3, 1'b0, 1'b0}); nb++;
    send_frame(1, 9'h0A3, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    qb.push_back('{9'h0A3, 1'b1, 1'b0}); nb++;
    send_frame(1, 9'h0A3, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    chk("b_done_cnt", 32'(done_b), 32'(nb));

    // stop bit low, then clean frame
    qa.push_back('{9'h03C, 1'b0, 1'b1}); na++;
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    qa.push_back('{9'h081, 1'b0, 1'b0}); na++;
    send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    chk("a_81_done_cnt", 32'(done_a), 32'(na));

    // 3-cycle glitch is a false start
    hold(0, 1'b0, 3);
    hold(0, 1'b1, BC);
    chk("glitch_busy", 32'(ifa.rx_busy), 32'd0);
    chk("glitch_done_cnt", 32'(done_a), 32'(na));
    chk("glitch_data", 32'(ifa.rx_data), 32'h81);
    chk("glitch_flags", {30'd0, ifa.parity_err, ifa.frame_err}, 32'd0);

    // enable dropped mid-DATA of 0xF0
    hold(0, 1'b0, 4 * BC);
    chk("abort_busy_mid", 32'(ifa.rx_busy), 32'd1);
    ifa.rx_en_sig = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy_low", 32'(ifa.rx_busy), 32'd0);
    hold(0, 1'b1, 2 * BC);
    chk("abort_done_cnt", 32'(done_a), 32'(na));
    chk("abort_data_kept", 32'(ifa.rx_data), 32'h81);
    ifa.rx_en_sig = 1'b1;
    hold(0, 1'b1, BC);
    qa.push_back('{9'h00F, 1'b0, 1'b0}); na++;
    send_frame(0, 9'h00F, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    chk("a_0f_done_cnt", 32'(done_a), 32'(na));

    // break: one frame of zeros with frame error, no re-trigger while low
    qa.push_back('{9'h000, 1'b0, 1'b1}); na++;
    hold(0, 1'b0, 14 * BC);
    chk("break_done_cnt", 32'(done_a), 32'(na));
    chk("break_busy", 32'(ifa.rx_busy), 32'd0);
    hold(0, 1'b1, 2 * BC);

    // 7O2: clean, then second stop bit low
    qc.push_back('{9'h05A, 1'b0, 1'b0}); nc++;
    send_frame(2, 9'h05A, 7, 1'b1, 1'b1, 2, 1'b1, 1'b1);
    qc.push_back('{9'h05A, 1'b0, 1'b1}); nc++;
    send_frame(2, 9'h05A, 7, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    chk("c_done_cnt", 32'(done_c), 32'(nc));

    // asynchronous reset mid-frame
    hold(0, 1'b0, 3 * BC);
    chk("rst_mid_busy_before", 32'(ifa.rx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(ifa.rx_busy), 32'd0);
    chk("rst_mid_ferr", 32'(ifa.frame_err), 32'd0);
    chk("rst_mid_data", 32'(ifa.rx_data), 32'd0);
    set_pin(0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(0, 1'b1, 2 * BC);
    chk("rst_mid_done_cnt", 32'(done_a), 32'(na));
    chk("queues_drained", 32'(qa.size() + qb.size() + qc.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised serial receiver, successor to the fixed 8N1 receive path in the exp09 environment.
- Configurable baud divisor, data width, parity mode and stop-bit count.
- 3-sample majority vote at mid-bit; reports parity and framing errors.
- Sits between the sq_pin line and the system-side enable/done handshake, driven by the tx/rx environment benches.

Parameters:
- CLK_HZ, 20000000, system clock frequency in Hz.
- BAUD, 9600, line rate. BIT_CNT = CLK_HZ/BAUD (integer divide); must be >= 8.
- DATA_BITS, 8, payload bits per frame, legal range 5..9, sent LSB first.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked, 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset.
- rx_en_sig  in  1  receive enable; level, held high while a frame is wanted.
- rx_pin  in  1  asynchronous serial line; idles high.
- rx_done  out  1  one-cycle pulse, frame complete.
- rx_data  out  DATA_BITS  last received payload.
- parity_err  out  1  parity mismatch on last frame.
- frame_err  out  1  stop bit sampled low on last frame.
- rx_busy  out  1  high from start-edge detection until return to IDLE.

Interface decision: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: all outputs 0. Synchroniser flops = 1. State = IDLE. Counters = 0.
- Input path: rx_pin passes through a 2-FF synchroniser, then 1 history flop.
- Falling edge = history 1 and synchronised 0.
- Bit timer: counts 0..BIT_CNT-1 within each bit, then wraps to 0.
- Sampling: synchronised line is sampled at counts MID-1, MID and MID+1, where MID = BIT_CNT/2. The bit value is the majority of the 3 samples.
- IDLE: rx_busy=0. On falling edge while rx_en_sig=1, go to START with the timer cleared. Edges while rx_en_sig=0 are ignored.
- START:
  - At MID+1, a majority of 1 is a false start: return to IDLE, no rx_done, error flags unchanged.
  - Otherwise continue; at timer wrap go to DATA.
- DATA:
  - Shift the majority value in LSB first at MID+1.
  - After DATA_BITS bits, go to PARITY if PARITY != 0, else to STOP.
- PARITY:
  - Sampled bit is XOR'd with the data.
  - Odd mode: the XOR of data and parity bit must be 1. Even mode: it must be 0.
  - Mismatch sets the internal perr.
- STOP:
  - Each stop bit is sampled at MID+1; any 0 sets the internal ferr.
  - For the final stop bit, the DONE transition occurs at MID+1; the remaining half bit is not waited for.
  - With STOP_BITS=2, the first stop bit completes a full BIT_CNT before the second begins.
- DONE (one cycle):
  - rx_done=1.
  - rx_data, parity_err and frame_err update on the same edge; all three are held until the next completed frame.
  - Then go to IDLE.
- Latency: rx_done rises 3 + (frame bits before the final stop)·BIT_CNT + MID+2 cycles after the rx_pin falling edge, ±1 for synchroniser phase.
- Frames with errors still pulse rx_done and update rx_data; the flags qualify the data.
- rx_en_sig low in any non-IDLE state: abort to IDLE on the next edge. No rx_done; outputs unchanged.
- A new falling edge while in STOP or DONE is not accepted. A start edge is accepted only in IDLE, from the cycle after DONE.
- The line held low continuously (break) is received as data 0 with frame_err=1. No re-trigger happens until the line returns high and falls again.
- Asynchronous reset mid-frame: immediate return to reset values.
- Width rules:
  - Bit counter sized for DATA_BITS.
  - Timer width = $clog2(BIT_CNT).
  - No truncation of BIT_CNT/2.

Decomposition:
- Shared package uart_pkg holds:
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - state encoding IDLE, START, DATA, PARITY, STOP, DONE;
  - function bit_cnt(clk_hz, baud).
- One sub-module, uart_rx_sampler: synchroniser, edge detect and 3-sample majority. Inputs are clk, rst_n, rx_pin and timer; outputs are fall_edge, bit_val and sample_strobe.
- FSM, shifter and flags stay in uart_rx_param.

Test Plan:
- BAUD=1000000 (BIT_CNT=20), 8N1, rx_en_sig=1, frame 0x55 -> one rx_done pulse, rx_data=0x55, parity_err=0, frame_err=0, rx_busy then low.
- PARITY=2, frame 0xA3 with parity bit 0 -> rx_data=0xA3, parity_err=0. Same frame with parity bit 1 -> rx_data=0xA3, parity_err=1.
- Stop bit driven low for frame 0x3C -> rx_done pulses, rx_data=0x3C, frame_err=1. Next clean frame 0x81 -> frame_err=0.
- Glitch: rx_pin low for 3 cycles only -> no rx_done, rx_busy returns to 0 within BIT_CNT, flags unchanged.
- rx_en_sig dropped mid-DATA of 0xF0 -> no rx_done, rx_data keeps previous 0x81. Re-enable, then send 0x0F -> rx_data=0x0F.
- DATA_BITS=7, STOP_BITS=2, PARITY=1, frame 0x5A -> rx_data=7'h5A, parity_err=0. Second stop bit low -> frame_err=1.
